// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int NREQ            = 4;
    localparam int TIMEOUT_CYC_DEF = 60000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and sender bundle for the UART transmit arbiter.
interface uart_tx_arbiter_if;
    import uart_arb_pkg::*;

    // Requester i transfers its byte on the rising edge where req_valid[i] && req_ready[i];
    // a requester keeps valid and data stable until then. tx_en is a one-cycle start pulse
    // and tx_status=1 reports the sender idle.
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_status;

    modport master (
        output req_valid, req_data, tx_status,
        input  req_ready, tx_data, tx_en
    );

    modport slave (
        input  req_valid, req_data, tx_status,
        output req_ready, tx_data, tx_en
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin winner: search starts one past the last grant and wraps.
module uart_rr_pick
    import uart_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  logic [1:0]      grant_id,
    output logic [NREQ-1:0] winner,
    output logic            any
);

    logic [1:0] idx;

    always_comb begin
        winner = '0;
        idx    = grant_id;
        for (int k = 1; k <= NREQ; k++) begin
            idx = grant_id + 2'(k);
            if (req_valid[idx] && (winner == '0)) winner[idx] = 1'b1;
        end
    end

    assign any = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART sender.
// Define UART_ARB_TIMEOUT_EN to add the sender-handshake timeout and sticky err flag.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             CLK,
    input  logic             Reset_n,
    uart_tx_arbiter_if.slave bus,
    input  logic             err_clr,
    output logic             busy,
    output logic [1:0]       grant_id,
    output logic             err,
    output arb_state_t       state_dbg
);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] winner;
    logic            any_valid;
    logic            accept;
    logic [1:0]      win_idx;
    logic [1:0]      grant_q;
    logic [7:0]      tx_data_q;
    logic            timeout_hit;

    uart_rr_pick u_pick (
        .req_valid (bus.req_valid),
        .grant_id  (grant_q),
        .winner    (winner),
        .any       (any_valid)
    );

    // Grants only while idle and the sender itself reports idle.
    assign bus.req_ready = (state_q == IDLE && bus.tx_status && any_valid) ? winner : '0;
    assign accept        = |(bus.req_ready & bus.req_valid);
    assign win_idx       = onehot_to_idx(bus.req_ready);

    assign bus.tx_en   = (state_q == LAUNCH);
    assign bus.tx_data = tx_data_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign state_dbg   = state_q;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            grant_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tx_data_q <= bus.req_data[{win_idx, 3'b000} +: 8];
                grant_q   <= win_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_LOW;
            WAIT_LOW:  if (!bus.tx_status) state_d = WAIT_HIGH;
            WAIT_HIGH: if (bus.tx_status) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] to_cnt_q;
    logic        err_q;

    // The final allowed wait cycle abandons the byte; a same-cycle err_clr loses.
    assign timeout_hit = ((state_q == WAIT_LOW) || (state_q == WAIT_HIGH)) && (to_cnt_q == TO_LAST);

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                to_cnt_q <= '0;
            end else if ((state_q == WAIT_LOW) || (state_q == WAIT_HIGH)) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences, randomized traffic.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TB_TO = 100;
`else
    localparam int TB_TO = 60000;
`endif

    typedef struct {
        logic [3:0]  valid;
        logic        ts;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    logic       CLK     = 1'b0;
    logic       Reset_n = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [1:0] grant_id;
    logic       err;
    arb_state_t state_dbg;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[4][$];

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.TIMEOUT_CYC(TB_TO)) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .err_clr   (err_clr),
        .busy      (busy),
        .grant_id  (grant_id),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset_n       = 1'b0;
        err_clr       = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_status = 1'b1;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rr_model(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return 4'(1 << ((last + k) % 4));
        end
        return 4'b0;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(busy), 32'(0));
    endtask

    // Called in the tx_en cycle: sender goes busy, then idle again.
    task automatic finish_byte(input string name);
        bus.req_valid = '0;
        bus.tx_status = 1'b0;
        step();
        chk({name, "_en_once"}, 32'(bus.tx_en), 32'(0));
        step();
        bus.tx_status = 1'b1;
        wait_idle({name, "_idle"}, 10);
    endtask

    // ---------------- randomized traffic vs. transaction model ----------------
    task automatic run_random();
        logic [3:0]  v;
        logic [3:0]  er;
        logic [31:0] d;
        logic        ts;
        int          snd_pre, snd_low, m_last, m_age, idx, nb;
        bit          m_inflight, m_seen_low, done;
        m_last = 3; m_age = 0; idx = 0;
        m_inflight = 1'b0; m_seen_low = 1'b0; done = 1'b0;
        snd_pre = 0; snd_low = 0; ts = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            nb = $urandom_range(4, 10);
            for (int n = 0; n < nb; n++) src_q[i].push_back(8'($urandom));
        end
        for (int c = 0; c < 5000; c++) begin
            done = !m_inflight && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                   src_q[2].size() == 0 && src_q[3].size() == 0;
            if (done) break;
            v = '0;
            d = $urandom;
            for (int i = 0; i < 4; i++) begin
                if (src_q[i].size() != 0 && $urandom_range(0, 3) != 0) begin
                    v[i]         = 1'b1;
                    d[8*i +: 8]  = src_q[i][0];
                end
            end
            if (snd_pre > 0) begin
                ts = 1'b1; snd_pre--;
            end else if (snd_low > 0) begin
                ts = 1'b0; snd_low--;
            end else begin
                ts = ($urandom_range(0, 7) != 0);
            end
            bus.req_valid = v;
            bus.req_data  = d;
            bus.tx_status = ts;
            #1;
            er = (!m_inflight && ts) ? rr_model(m_last, v) : 4'b0;
            chk("rnd_ready", 32'(bus.req_ready), 32'(er));
            chk("rnd_tx_en", 32'(bus.tx_en), 32'(m_inflight && m_age == 0));
            if (m_inflight && m_age == 0) begin
                chk("rnd_tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                snd_pre = $urandom_range(0, 2);
                snd_low = $urandom_range(1, 4);
            end
            step();
            if (m_inflight) begin
                if (m_age >= 1) begin
                    if (!m_seen_low) begin
                        if (!ts) m_seen_low = 1'b1;
                    end else if (ts) begin
                        m_inflight = 1'b0;
                    end
                end
                m_age++;
            end else if (er != 4'b0) begin
                for (int i = 0; i < 4; i++) if (er[i]) idx = i;
                m_inflight = 1'b1; m_seen_low = 1'b0; m_age = 0; m_last = idx;
                exp_q.push_back(src_q[idx].pop_front());
                chk("rnd_grant", 32'(grant_id), 32'(idx));
            end
        end
        chk("rnd_drained", 32'(done), 32'(1));
        bus.req_valid = '0;
        bus.tx_status = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t       vecs[11];
        logic [7:0] last_byte;
        int         n;

        vecs[0]  = '{4'b1111, 1'b1, 32'h4332_2110, 4'b0001, 2'd0, 8'h10};
        vecs[1]  = '{4'b1111, 1'b1, 32'h4332_2110, 4'b0010, 2'd1, 8'h21};
        vecs[2]  = '{4'b1111, 1'b1, 32'h4332_2110, 4'b0100, 2'd2, 8'h32};
        vecs[3]  = '{4'b1111, 1'b1, 32'h4332_2110, 4'b1000, 2'd3, 8'h43};
        vecs[4]  = '{4'b0100, 1'b1, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5};
        vecs[5]  = '{4'b0011, 1'b1, 32'h4332_2110, 4'b0001, 2'd0, 8'h10};
        vecs[6]  = '{4'b1000, 1'b0, 32'h4332_2110, 4'b0000, 2'd0, 8'h00};
        vecs[7]  = '{4'b1010, 1'b1, 32'hDEAD_BEEF, 4'b0010, 2'd1, 8'hBE};
        vecs[8]  = '{4'b1001, 1'b1, 32'hDEAD_BEEF, 4'b1000, 2'd3, 8'hDE};
        vecs[9]  = '{4'b0000, 1'b1, 32'h4332_2110, 4'b0000, 2'd3, 8'h00};
        vecs[10] = '{4'b0110, 1'b1, 32'hCAFE_1234, 4'b0010, 2'd1, 8'h12};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_status = 1'b1;
        do_reset();

        chk("rst_tx_en",    32'(bus.tx_en),     32'(0));
        chk("rst_tx_data",  32'(bus.tx_data),   32'(0));
        chk("rst_grant",    32'(grant_id),      32'(3));
        chk("rst_err",      32'(err),           32'(0));
        chk("rst_busy",     32'(busy),          32'(0));
        chk("rst_state",    32'(state_dbg),     32'(IDLE));
        chk("rst_ready",    32'(bus.req_ready), 32'(0));

        // Vector table: each row starts from IDLE with the grant left by the previous row.
        last_byte = 8'h00;
        foreach (vecs[i]) begin
            bus.req_valid = vecs[i].valid;
            bus.req_data  = vecs[i].data;
            bus.tx_status = vecs[i].ts;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            step();
            chk($sformatf("v%0d_grant", i), 32'(grant_id), 32'(vecs[i].exp_grant));
            if (vecs[i].exp_ready != 4'b0) begin
                chk($sformatf("v%0d_tx_en", i),   32'(bus.tx_en),   32'(1));
                chk($sformatf("v%0d_tx_data", i), 32'(bus.tx_data), 32'(vecs[i].exp_byte));
                last_byte = vecs[i].exp_byte;
                finish_byte($sformatf("v%0d", i));
            end else begin
                chk($sformatf("v%0d_no_en", i),   32'(bus.tx_en),   32'(0));
                chk($sformatf("v%0d_idle", i),    32'(busy),        32'(0));
                chk($sformatf("v%0d_hold", i),    32'(bus.tx_data), 32'(last_byte));
            end
            bus.req_valid = '0;
            bus.tx_status = 1'b1;
        end

        // Back-to-back: requester 1 stays valid while the sender is busy for 5 cycles.
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_7700;
        #1;
        chk("b2b_first_ready", 32'(bus.req_ready), 32'(4'b0010));
        step();
        chk("b2b_first_en",   32'(bus.tx_en),   32'(1));
        chk("b2b_first_data", 32'(bus.tx_data), 32'(8'h77));
        bus.req_data  = 32'h0000_8800;
        bus.tx_status = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("b2b_busy_ready%0d", k), 32'(bus.req_ready), 32'(0));
            chk($sformatf("b2b_busy%0d", k),       32'(busy),          32'(1));
            step();
        end
        bus.tx_status = 1'b1;
        #1;
        chk("b2b_wait_high_ready", 32'(bus.req_ready), 32'(0));
        step();
        #1;
        chk("b2b_idle_ready", 32'(bus.req_ready), 32'(4'b0010));
        chk("b2b_idle_busy",  32'(busy),          32'(0));
        step();
        chk("b2b_second_en",   32'(bus.tx_en),   32'(1));
        chk("b2b_second_data", 32'(bus.tx_data), 32'(8'h88));
        finish_byte("b2b");

        // Sender busy while idle: no grant until tx_status returns high.
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0066;
        bus.tx_status = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ext_busy_ready%0d", k), 32'(bus.req_ready), 32'(0));
            step();
            chk($sformatf("ext_busy_no_en%0d", k), 32'(bus.tx_en), 32'(0));
        end
        bus.tx_status = 1'b1;
        #1;
        chk("ext_free_ready", 32'(bus.req_ready), 32'(4'b0001));
        step();
        chk("ext_free_en",   32'(bus.tx_en),   32'(1));
        chk("ext_free_data", 32'(bus.tx_data), 32'(8'h66));
        finish_byte("ext");

        // Reset while waiting for the sender to finish: byte abandoned.
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h005A_0000;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'(4'b0100));
        step();
        chk("abort_en",    32'(bus.tx_en), 32'(1));
        chk("abort_grant", 32'(grant_id),  32'(2));
        bus.req_valid = '0;
        bus.tx_status = 1'b0;
        step();
        step();
        chk("abort_in_wait_high", 32'(state_dbg), 32'(WAIT_HIGH));
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        chk("abort_state",   32'(state_dbg),   32'(IDLE));
        chk("abort_tx_en",   32'(bus.tx_en),   32'(0));
        chk("abort_grant3",  32'(grant_id),    32'(3));
        chk("abort_tx_data", 32'(bus.tx_data), 32'(0));
        bus.tx_status = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("abort_no_ready%0d", k), 32'(bus.req_ready), 32'(0));
            step();
            chk($sformatf("abort_no_en%0d", k), 32'(bus.tx_en), 32'(0));
        end

        // Sender never answers after tx_en.
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0099;
        bus.tx_status = 1'b1;
        step();
        chk("stuck_en", 32'(bus.tx_en), 32'(1));
        bus.req_valid = '0;
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("to_cycles", 32'(n), 32'(TB_TO + 1));
        chk("to_err_set", 32'(err), 32'(1));
        step();
        step();
        chk("to_err_sticky", 32'(err), 32'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_err_clr", 32'(err), 32'(0));
        chk("to_idle", 32'(busy), 32'(0));
`else
        n = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (busy) n++;
        end
        chk("stuck_still_busy", 32'(n),   32'(150));
        chk("stuck_err_zero",   32'(err), 32'(0));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stuck_err_clr", 32'(err), 32'(0));
`endif

        do_reset();
        chk("rnd_start_grant", 32'(grant_id), 32'(3));
        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
